// File: rtl/smg_pkg.sv
// Shared definitions for the FIFO-fed 7-segment display: fetch FSM states, hex segment map, digit count.
// Segment codes are active-high {dp,g,f,e,d,c,b,a}; output polarity is applied at the top level.
package smg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_LATCH = 2'd2
    } fetch_state_t;

    localparam int NUM_DIGITS = 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [7:0] SEG_DASH  = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Entry [n] is the pattern for hex digit n; listed from F down to 0.
    localparam logic [15:0][7:0] HEX7_TABLE = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

    function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [IDX_W-1:0] idx);
        return NUM_DIGITS'(1) << idx;
    endfunction

endpackage

// File: rtl/smg_hex7.sv
// Nibble to active-high 7-segment pattern, dp always off.
// Purely combinational, zero latency, no flow control.
module smg_hex7
    import smg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    assign seg = HEX7_TABLE[nibble];

endmodule

// File: rtl/smg_fifo_disp.sv
// Fetches {addr,data} words from a FIFO on request and scans them onto a 4-digit 7-segment display.
// Word visible 3 cycles after request; requests during a fetch are dropped; SMG_LEADZERO_BLANK_EN blanks leading zeros.
module smg_fifo_disp
    import smg_pkg::*;
#(
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit SEL_ACT_LOW = 1'b1
) (
    input  logic                  clk_50MHz,
    input  logic                  rst,
    input  logic                  clk_1khz,
    input  logic                  rdsig_nextdata,
    input  logic                  fifo_empty,
    input  logic [15:0]           fifo_rdata,
    output logic                  fifo_rd_en,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] sel,
    output logic                  disp_valid,
    output logic                  underrun
);

    fetch_state_t     state;
    logic [15:0]      disp_word;

    logic             k1;
    logic             k2;
    logic             tick;
    logic [IDX_W-1:0] digit_idx;
    logic [3:0]       nibble;
    logic [7:0]       hex_seg;
    logic             lead_blank;
    logic [7:0]       seg_next;

    // Fetch FSM: rd_en is asserted together with entry into READ, so the FIFO
    // returns data during LATCH, where it is captured.
    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            fifo_rd_en <= 1'b0;
            underrun   <= 1'b0;
            disp_word  <= 16'h0000;
            disp_valid <= 1'b0;
        end else begin
            fifo_rd_en <= 1'b0;
            underrun   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rdsig_nextdata) begin
                        if (fifo_empty) begin
                            underrun <= 1'b1;
                        end else begin
                            state      <= ST_READ;
                            fifo_rd_en <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    state <= ST_LATCH;
                end
                ST_LATCH: begin
                    disp_word  <= fifo_rdata;
                    disp_valid <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tick   = k1 & ~k2;
    assign nibble = disp_word[{digit_idx, 2'b00} +: 4];

    smg_hex7 u_hex7 (
        .nibble (nibble),
        .seg    (hex_seg)
    );

`ifdef SMG_LEADZERO_BLANK_EN
    // A digit is a leading zero when it and every digit to its left are zero.
    always_comb begin
        lead_blank = 1'b0;
        case (digit_idx)
            2'd3:    lead_blank = (disp_word[15:12] == 4'h0);
            2'd2:    lead_blank = (disp_word[15:8]  == 8'h00);
            2'd1:    lead_blank = (disp_word[15:4]  == 12'h000);
            default: lead_blank = 1'b0;
        endcase
    end
`else
    assign lead_blank = 1'b0;
`endif

    always_comb begin
        seg_next = hex_seg;
        if (!disp_valid) begin
            seg_next = SEG_DASH;
        end else if (lead_blank) begin
            seg_next = SEG_BLANK;
        end
    end

    // Outputs stay dark after reset until the first tick lights digit 0.
    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            k1        <= 1'b0;
            k2        <= 1'b0;
            digit_idx <= '0;
            seg       <= {8{SEG_ACT_LOW}};
            sel       <= {NUM_DIGITS{SEL_ACT_LOW}};
        end else begin
            k1 <= clk_1khz;
            k2 <= k1;
            if (tick) begin
                seg       <= seg_next ^ {8{SEG_ACT_LOW}};
                sel       <= digit_onehot(digit_idx) ^ {NUM_DIGITS{SEL_ACT_LOW}};
                digit_idx <= digit_idx + IDX_W'(1);
            end
        end
    end

endmodule
